// File: rtl/multi_countdown_pkg.sv
// Shared types, command codes and the preset sanitiser for the multi-channel
// MM:SS BCD countdown block.
package multi_countdown_pkg;

  localparam int BCD_W = 4;
  localparam int DIGITS = 4;
  localparam int CNT_W = BCD_W * DIGITS;

  localparam logic [1:0] CMD_LOAD        = 2'd0;
  localparam logic [1:0] CMD_START       = 2'd1;
  localparam logic [1:0] CMD_STOP        = 2'd2;
  localparam logic [1:0] CMD_CLEAR_ALARM = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Clamp each BCD digit to its legal range: {min_tens, min_ones, sec_tens, sec_ones}.
  function automatic logic [CNT_W-1:0] sanitise(input logic [CNT_W-1:0] d);
    logic [BCD_W-1:0] mt, mo, st, so;
    mt = (d[15:12] > 4'd9) ? 4'd9 : d[15:12];
    mo = (d[11:8]  > 4'd9) ? 4'd9 : d[11:8];
    st = (d[7:4]   > 4'd5) ? 4'd5 : d[7:4];
    so = (d[3:0]   > 4'd9) ? 4'd9 : d[3:0];
    return {mt, mo, st, so};
  endfunction

endpackage

// File: rtl/countdown_channel.sv
// One MM:SS countdown channel: control FSM, preset and count registers and
// the BCD borrow chain used for the per-second decrement.
module countdown_channel
  import multi_countdown_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic              cmd_hit,
  input  logic [1:0]        cmd,
  input  logic [CNT_W-1:0]  preset,
  input  logic              auto_reload,
  output logic [CNT_W-1:0]  digits,
  output logic              running,
  output logic              done_pulse,
  output logic              alarm
);

  state_t            state;
  logic [CNT_W-1:0]  preset_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_dec;
  logic [BCD_W-1:0]  mt, mo, st, so;

  // MM:SS borrow chain; seconds wrap 0 -> 59, minutes ones wrap 0 -> 9.
  always_comb begin
    mt = count_q[15:12];
    mo = count_q[11:8];
    st = count_q[7:4];
    so = count_q[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    count_dec = {mt, mo, st, so};
  end

  // A command to this channel takes priority; a tick in the same cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      preset_q   <= '0;
      count_q    <= '0;
      running    <= 1'b0;
      done_pulse <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (cmd_hit) begin
        case (cmd)
          CMD_LOAD: begin
            preset_q <= sanitise(preset);
            count_q  <= sanitise(preset);
            state    <= IDLE;
            running  <= 1'b0;
          end
          CMD_START: begin
            if (preset_q != '0) begin
              if (state != PAUSE) count_q <= preset_q;
              state   <= RUN;
              running <= 1'b1;
            end
          end
          CMD_STOP: begin
            if (state == RUN) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          CMD_CLEAR_ALARM: alarm <= 1'b0;
          default: ;
        endcase
      end else if (tick_en && state == RUN) begin
        if (count_q == 16'h0001) begin
          done_pulse <= 1'b1;
          alarm      <= 1'b1;
          if (auto_reload) begin
            count_q <= preset_q;
          end else begin
            count_q <= '0;
            state   <= EXPIRED;
            running <= 1'b0;
          end
        end else begin
          count_q <= count_dec;
        end
      end
    end
  end

  assign digits = count_q;

endmodule

// File: rtl/multi_countdown.sv
// CHANNELS independent MM:SS countdown timers sharing one 1 s tick, with a
// channel-addressed command port and flattened per-channel digit outputs.
module multi_countdown
  import multi_countdown_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      global_en,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [CNT_W-1:0]          preset_digits,
  input  logic [CHANNELS-1:0]       auto_reload,
  output logic [CNT_W*CHANNELS-1:0] digits,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       done_pulse,
  output logic [CHANNELS-1:0]       alarm
);

  // cmd_valid is a one-cycle strobe with no ready: it is always accepted on the
  // edge where it is high, and a cmd_ch matching no channel is silently dropped.
  logic tick_en;
  assign tick_en = tick & global_en;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic cmd_hit;
    assign cmd_hit = cmd_valid && (cmd_ch == CH_W'(k));

    countdown_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick_en     (tick_en),
      .cmd_hit     (cmd_hit),
      .cmd         (cmd),
      .preset      (preset_digits),
      .auto_reload (auto_reload[k]),
      .digits      (digits[CNT_W*k +: CNT_W]),
      .running     (running[k]),
      .done_pulse  (done_pulse[k]),
      .alarm       (alarm[k])
    );
  end

endmodule
